// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the front end: datapath width, the bubble
// instruction, and the IF/ID record.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_id_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO with a registered head; push and pop may coincide when
// non-empty, and flush/rst empty it.
module fetch_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot [2];
  logic [1:0]       count_reg;
  logic             do_push;
  logic             do_pop;
  logic             wr_idx;

  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && ((count_reg != 2'd2) || do_pop);
  // Slot 0 is always the head; a pop shifts slot 1 down before the write lands.
  assign wr_idx  = (count_reg == 2'd2) || ((count_reg == 2'd1) && !do_pop);
  assign head    = slot[0];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_reg <= 2'd0;
    end else begin
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_pop) begin
      slot[0] <= slot[1];
    end
    if (do_push) begin
      slot[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited requests to instruction memory,
// in-order response buffering, branch redirect with stale-response drop.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_enable,
  input  logic            if_id_enable,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_inst,
  output logic            fetch_err
);

  logic [XLEN-1:0]   pc_reg;
  logic [1:0]        drop_cnt_reg;
  logic              err_reg;
  if_id_t            if_id_reg;
  logic [1:0]        outstanding;
  logic [1:0]        buf_count;
  logic [XLEN-1:0]   addr_head;
  logic [2*XLEN-1:0] buf_head;
  logic [2:0]        credits_used;
  logic              req_fire;
  logic              rsp_ok;
  logic              rsp_keep;
  logic              buf_pop;

  // In-flight plus buffered words never exceed two, so the buffer cannot overflow.
  assign credits_used   = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req_valid = !rst && pc_enable && !branch_taken && (credits_used < 3'd2);
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && (outstanding != 2'd0);
  assign rsp_keep       = rsp_ok && !branch_taken && (drop_cnt_reg == 2'd0);
  assign buf_pop        = if_id_enable && !branch_taken && (buf_count != 2'd0);

  // The address FIFO depth doubles as the outstanding-request counter.
  fetch_fifo2 #(.WIDTH(XLEN)) u_addr_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc_reg),
    .pop       (rsp_ok),
    .head      (addr_head),
    .count     (outstanding)
  );

  fetch_fifo2 #(.WIDTH(2*XLEN)) u_rsp_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (rsp_keep),
    .push_data ({addr_head, imem_rsp_data}),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      drop_cnt_reg <= 2'd0;
      err_reg      <= 1'b0;
      if_id_reg    <= '{valid: 1'b0, pc: '0, inst: NOP_INST};
    end else begin
      if (branch_taken) begin
        pc_reg <= {branch_target[XLEN-1:2], 2'b00};
      end else if (req_fire) begin
        pc_reg <= pc_reg + 32'd4;
      end

      // A response landing in the redirect cycle is already discarded here.
      if (branch_taken) begin
        drop_cnt_reg <= outstanding - {1'b0, rsp_ok};
      end else if (rsp_ok && (drop_cnt_reg != 2'd0)) begin
        drop_cnt_reg <= drop_cnt_reg - 2'd1;
      end

      if (imem_rsp_valid && (outstanding == 2'd0)) begin
        err_reg <= 1'b1;
      end

      if (branch_taken || (if_id_enable && (buf_count == 2'd0))) begin
        if_id_reg.valid <= 1'b0;
        if_id_reg.inst  <= NOP_INST;
      end else if (if_id_enable) begin
        if_id_reg <= '{valid: 1'b1, pc: buf_head[2*XLEN-1:XLEN], inst: buf_head[XLEN-1:0]};
      end
    end
  end

  assign if_id_valid = if_id_reg.valid;
  assign if_id_pc    = if_id_reg.pc;
  assign if_id_inst  = if_id_reg.inst;
  assign fetch_err   = err_reg;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, SHALL set the instruction word used for IF/ID bubbles.
REQ-003 clk  in  1  SHALL be the rising-edge clock for all state.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 pc_enable  in  1  SHALL allow a new fetch request when 1, from hazard control.
REQ-006 if_id_enable  in  1  SHALL allow the IF/ID register to update when 1; 0 holds it.
REQ-007 branch_taken  in  1  SHALL redirect fetch and flush in a single cycle.
REQ-008 branch_target  in  32  SHALL carry the redirect address.
REQ-009 imem_req_valid  out  1  SHALL indicate a valid fetch request.
REQ-010 imem_req_addr  out  32  SHALL carry the fetch address, equal to the current PC.
REQ-011 imem_req_ready  in  1  SHALL indicate that memory accepts the request.
REQ-012 imem_rsp_valid  in  1  SHALL mark an in-order instruction response.
REQ-013 imem_rsp_data  in  32  SHALL carry the response instruction word.
REQ-014 if_id_valid / if_id_pc / if_id_inst  out  1/32/32  SHALL carry the IF/ID register contents.
REQ-015 fetch_err  out  1  SHALL be a sticky flag for a response received with no request outstanding.

Function
REQ-016 Request accepted = imem_req_valid && imem_req_ready; on acceptance:
  - PC <= PC+4;
  - accepted address pushed into a 2-entry address FIFO;
  - outstanding++.
REQ-017 imem_req_valid SHALL be pc_enable && !branch_taken && (outstanding + buf_count < 2).
  - pc_enable=0 blocks only new requests; responses still accepted.
REQ-018 Response with drop_cnt>0 handling:
  - drop_cnt--, outstanding--;
  - address FIFO head popped;
  - data discarded.
REQ-019 Response with drop_cnt=0 handling:
  - {address FIFO head, imem_rsp_data} pushed into a 2-entry response buffer;
  - outstanding--.
REQ-020 Response with outstanding=0 handling:
  - response ignored;
  - fetch_err set, held until rst.
REQ-021 if_id_enable=1 && buffer non-empty SHALL load the buffer head into IF/ID with if_id_valid=1 and pop the buffer.
REQ-022 if_id_enable=1 && buffer empty SHALL load a bubble: if_id_valid=0, if_id_inst=NOP_INST, if_id_pc held.
REQ-023 No same-cycle bypass: minimum response-to-IF/ID latency SHALL be 1 cycle after buffering (response at edge N, IF/ID valid after edge N+1).
REQ-024 branch_taken=1 SHALL have priority over all other events that cycle:
  - PC <= {branch_target[31:2],2'b00};
  - response buffer cleared;
  - IF/ID <= bubble regardless of if_id_enable;
  - drop_cnt <= outstanding minus any response arriving that cycle;
  - no request issued.
REQ-025 A response arriving in the branch_taken cycle SHALL be discarded and SHALL decrement outstanding.
REQ-026 Simultaneous buffer push and pop SHALL be legal at buf_count=1 or 2.
  - The credit rule guarantees the buffer never overflows.
REQ-027 PC SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
REQ-028 outstanding, drop_cnt and buf_count SHALL each be 2 bits, range 0..2.

Reset
REQ-029 rst SHALL set the following on the next edge, overriding all other inputs:
  - PC=RESET_PC;
  - outstanding, drop_cnt, buf_count = 0;
  - fetch_err=0;
  - if_id_valid=0, if_id_inst=NOP_INST, if_id_pc=0.
REQ-030 Requests SHALL NOT issue while rst=1; imem_req_valid=0.
REQ-031 Reset mid-operation SHALL abandon in-flight requests; the memory is reset by the same rst.

Structure
REQ-032 A shared pipeline package SHALL hold NOP_INST, XLEN=32 and the IF/ID record type {valid, pc, inst}.
REQ-033 A 2-entry FIFO sub-module, fetch_fifo2 (parameterised width, push/pop/flush, count), SHALL be instantiated twice: once for the address FIFO and once for the response buffer.

Verification
REQ-034 Reset, then ready=1 and 1-cycle response latency -> addresses 0,4,8,... issued; IF/ID valid pc 0 at the edge after first buffering.
REQ-035 if_id_enable=0 for 3 cycles with 2 fetches in flight -> IF/ID held, buffer reaches 2, imem_req_valid=0, no data lost; resume -> pcs continue in order.
REQ-036 branch_taken target 32'h0000_0102 with outstanding=2 -> PC=32'h0000_0100, IF/ID bubble NOP_INST, next two responses dropped, first valid IF/ID pc=0x100.
REQ-037 branch_taken in the same cycle as rsp_valid and if_id_enable=0 -> response dropped, drop_cnt=outstanding-1, IF/ID still flushed.
REQ-038 rsp_valid with outstanding=0 -> fetch_err=1 sticky, IF/ID unaffected; rst -> fetch_err=0.
REQ-039 RESET_PC=32'hFFFF_FFF8, ready=1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; rst asserted mid-stream -> all outputs at reset values on the next cycle.
